alu_issue_ctrl: RTL and testbench

//  Instruction sequencer that drives the 8-bit ALU: decodes 9-bit instructions, reads an internal 8x8

---
 rtl/alu_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Three-phase instruction sequencer for the 8-bit ALU: decode and operand issue,
// result capture, then writeback, PC advance and branch statistics.
module alu_issue_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [8:0]       instr,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_func,
  output logic [2:0]       alu_spec,
  input  logic [7:0]       alu_res,
  input  logic             alu_carry,
  input  logic             alu_br,
  output logic [PC_W-1:0]  pc,
  output logic             carry_flag,
  output logic             illegal_op,
  output logic [CNT_W-1:0] num_bran_taken,
  output logic [CNT_W-1:0] num_bran_not_taken,
  input  logic [2:0]       dbg_addr,
  output logic [7:0]       dbg_data
);

  // state     | meaning
  // ST_IDLE   | ready for an instruction; accept edge registers decoded operands
  // ST_ISSUE  | operands held on the ALU; edge captures res/carry/br
  // ST_COMMIT | edge writes back, advances pc, updates flags and counters
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_RES  = 2'd1,
    WB_A    = 2'd2,
    WB_B    = 2'd3
  } wb_sel_t;

  localparam logic [3:0] FUNC_IDLE = 4'b1111;

  state_t           state_q, state_d;
  logic [7:0]       rf_q [0:7];
  logic [7:0]       rf_d [0:7];
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] not_taken_q, not_taken_d;
  logic             carry_flag_q, carry_flag_d;
  logic             illegal_q, illegal_d;
  logic [7:0]       alu_a_q, alu_a_d;
  logic [7:0]       alu_b_q, alu_b_d;
  logic [3:0]       alu_func_q, alu_func_d;
  logic [2:0]       alu_spec_q, alu_spec_d;
  logic [2:0]       dest_q, dest_d;
  wb_sel_t          wb_sel_q, wb_sel_d;
  logic             is_br_q, is_br_d;
  logic             is_add_q, is_add_d;
  logic             bad_q, bad_d;
  logic [7:0]       res_q, res_d;
  logic             cout_q, cout_d;
  logic             br_q, br_d;

  logic [3:0]       op;
  logic [2:0]       ra;
  logic [2:0]       rb;
  logic [2:0]       rs;
  logic [7:0]       dec_a;
  logic [7:0]       dec_b;
  logic [2:0]       dec_spec;
  logic [2:0]       dec_dest;
  wb_sel_t          dec_wb;
  logic             dec_br;
  logic             dec_add;
  logic             dec_bad;
  logic             accept;

  assign op = instr[8:5];
  assign ra = instr[4:2];
  assign rb = {1'b0, instr[1:0]};
  assign rs = {2'b00, instr[0]};

  always_comb begin
    dec_a    = rf_q[ra];
    dec_b    = rf_q[rb];
    dec_spec = 3'b000;
    dec_dest = ra;
    dec_wb   = WB_NONE;
    dec_br   = 1'b0;
    dec_add  = 1'b0;
    dec_bad  = 1'b0;
    case (op)
      4'b0000: begin
        dec_wb  = WB_RES;
        dec_add = 1'b1;
      end
      4'b0011, 4'b0100: dec_wb = WB_RES;
      4'b0101: dec_wb = WB_B;
      4'b0110: begin
        dec_dest = rb;
        dec_wb   = WB_A;
      end
      4'b0111: begin
        dec_spec = instr[4:2];
        dec_a    = rf_q[rb];
        dec_b    = 8'h00;
        dec_dest = rb;
        case (instr[4:2])
          3'b000, 3'b001, 3'b011, 3'b100: dec_wb = WB_RES;
          default:                         dec_bad = 1'b1;
        endcase
      end
      4'b1010, 4'b1011: begin
        dec_a    = rf_q[rs];
        dec_b    = {4'b0000, instr[4:1]};
        dec_dest = rs;
        dec_wb   = WB_RES;
      end
      4'b1100, 4'b1101: dec_br = 1'b1;
      default: dec_bad = 1'b1;
    endcase
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    state_d      = state_q;
    rf_d         = rf_q;
    pc_d         = pc_q;
    taken_d      = taken_q;
    not_taken_d  = not_taken_q;
    carry_flag_d = carry_flag_q;
    illegal_d    = illegal_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_func_d   = alu_func_q;
    alu_spec_d   = alu_spec_q;
    dest_d       = dest_q;
    wb_sel_d     = wb_sel_q;
    is_br_d      = is_br_q;
    is_add_d     = is_add_q;
    bad_d        = bad_q;
    res_d        = res_q;
    cout_d       = cout_q;
    br_d         = br_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_a_d    = dec_a;
          alu_b_d    = dec_b;
          alu_func_d = op;
          alu_spec_d = dec_spec;
          dest_d     = dec_dest;
          wb_sel_d   = dec_wb;
          is_br_d    = dec_br;
          is_add_d   = dec_add;
          bad_d      = dec_bad;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        res_d   = alu_res;
        cout_d  = alu_carry;
        br_d    = alu_br;
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        case (wb_sel_q)
          WB_RES:  rf_d[dest_q] = res_q;
          WB_A:    rf_d[dest_q] = alu_a_q;
          WB_B:    rf_d[dest_q] = alu_b_q;
          default: ;
        endcase
        // Branch targets come from r7; everything else falls through.
        if (is_br_q && br_q) begin
          pc_d = PC_W'(rf_q[7]);
          if (taken_q != {CNT_W{1'b1}}) taken_d = taken_q + CNT_W'(1);
        end else begin
          pc_d = pc_q + PC_W'(1);
          if (is_br_q && (not_taken_q != {CNT_W{1'b1}}))
            not_taken_d = not_taken_q + CNT_W'(1);
        end
        if (is_add_q) carry_flag_d = cout_q;
        if (bad_q) illegal_d = 1'b1;
        alu_func_d = FUNC_IDLE;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < 8; i++) rf_q[i] <= 8'h00;
      pc_q         <= '0;
      taken_q      <= '0;
      not_taken_q  <= '0;
      carry_flag_q <= 1'b0;
      illegal_q    <= 1'b0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_func_q   <= FUNC_IDLE;
      alu_spec_q   <= 3'b000;
      dest_q       <= 3'b000;
      wb_sel_q     <= WB_NONE;
      is_br_q      <= 1'b0;
      is_add_q     <= 1'b0;
      bad_q        <= 1'b0;
      res_q        <= 8'h00;
      cout_q       <= 1'b0;
      br_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_q         <= rf_d;
      pc_q         <= pc_d;
      taken_q      <= taken_d;
      not_taken_q  <= not_taken_d;
      carry_flag_q <= carry_flag_d;
      illegal_q    <= illegal_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_func_q   <= alu_func_d;
      alu_spec_q   <= alu_spec_d;
      dest_q       <= dest_d;
      wb_sel_q     <= wb_sel_d;
      is_br_q      <= is_br_d;
      is_add_q     <= is_add_d;
      bad_q        <= bad_d;
      res_q        <= res_d;
      cout_q       <= cout_d;
      br_q         <= br_d;
    end
  end

  assign alu_a              = alu_a_q;
  assign alu_b              = alu_b_q;
  assign alu_func           = alu_func_q;
  assign alu_spec           = alu_spec_q;
  assign pc                 = pc_q;
  assign carry_flag         = carry_flag_q;
  assign illegal_op         = illegal_q;
  assign num_bran_taken     = taken_q;
  assign num_bran_not_taken = not_taken_q;
  assign dbg_data           = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; the bench plays the ALU (real add and compare,
// injected results for other ops). Counters are narrowed to 4 bits to reach saturation.
module tb_alu_issue_ctrl;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [8:0] instr = '0;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [3:0] alu_func;
  logic [2:0] alu_spec;
  logic       alu_carry, alu_br;
  logic [7:0] pc;
  logic       carry_flag, illegal_op;
  logic [3:0] num_bran_taken, num_bran_not_taken;
  logic [2:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  logic [7:0] res_ovr = 8'h00;
  logic       carry_ovr = 1'b0;
  logic [7:0] rv;
  int n_checks = 0;
  int n_pass = 0;

  alu_issue_ctrl #(.PC_W(8), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_spec(alu_spec),
    .alu_res(alu_res), .alu_carry(alu_carry), .alu_br(alu_br), .pc(pc),
    .carry_flag(carry_flag), .illegal_op(illegal_op), .num_bran_taken(num_bran_taken),
    .num_bran_not_taken(num_bran_not_taken), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  assign {alu_carry, alu_res} = (alu_func == 4'b0000) ? ({1'b0, alu_a} + {1'b0, alu_b})
                                                      : {carry_ovr, res_ovr};
  assign alu_br = (alu_func == 4'b1100) ? (alu_a == alu_b) :
                  (alu_func == 4'b1101) ? (alu_a < alu_b) : 1'b0;

  task automatic peek(input logic [2:0] idx);
    dbg_addr = idx;
    #1;
    rv = dbg_data;
  endtask

  // Present an instruction and return one step after the accept edge (DUT in ISSUE).
  task automatic issue(input logic [8:0] ins);
    int w = 0;
    while (instr_ready !== 1'b1 && w < 10) begin
      @(posedge clock); #1; w++;
    end
    n_checks++; if (instr_ready !== 1'b1) $display("FAIL ready_timeout got %b want 1", instr_ready); else n_pass++;
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    instr = '0;
  endtask

  task automatic finish_instr();
    @(posedge clock); #1;
    @(posedge clock); #1;
  endtask

  task automatic run_instr(input logic [8:0] ins);
    issue(ins);
    finish_instr();
  endtask

  task automatic load_reg(input logic [2:0] idx, input logic [7:0] val);
    res_ovr = val;
    run_instr({4'b0011, idx, 2'b00});
  endtask

  task automatic test_reset();
    #17 reset_n = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (instr_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", instr_ready); else n_pass++;
    n_checks++; if (pc !== 8'h00) $display("FAIL rst_pc got %h want 00", pc); else n_pass++;
    n_checks++; if (alu_func !== 4'b1111) $display("FAIL rst_func got %b want 1111", alu_func); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_spec} !== 19'h0) $display("FAIL rst_operands got %h want 0", {alu_a, alu_b, alu_spec}); else n_pass++;
    n_checks++; if ({carry_flag, illegal_op} !== 2'b00) $display("FAIL rst_flags got %b want 00", {carry_flag, illegal_op}); else n_pass++;
    n_checks++; if ({num_bran_taken, num_bran_not_taken} !== 8'h00) $display("FAIL rst_counters got %h want 00", {num_bran_taken, num_bran_not_taken}); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      peek(3'(i));
      n_checks++; if (rv !== 8'h00) $display("FAIL rst_reg%0d got %h want 00", i, rv); else n_pass++;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_add();
    load_reg(3'd1, 8'hF0);
    load_reg(3'd2, 8'h20);
    issue({4'b0000, 3'd1, 2'd2});
    n_checks++; if (alu_func !== 4'b0000) $display("FAIL add_func got %b want 0000", alu_func); else n_pass++;
    n_checks++; if ({alu_a, alu_b} !== 16'hF020) $display("FAIL add_operands got %h want f020", {alu_a, alu_b}); else n_pass++;
    n_checks++; if (instr_ready !== 1'b0) $display("FAIL add_ready_issue got %b want 0", instr_ready); else n_pass++;
    @(posedge clock); #1;
    n_checks++; if (instr_ready !== 1'b0) $display("FAIL add_ready_commit got %b want 0", instr_ready); else n_pass++;
    @(posedge clock); #1;
    peek(3'd1);
    n_checks++; if (rv !== 8'h10) $display("FAIL add_r1 got %h want 10", rv); else n_pass++;
    n_checks++; if (carry_flag !== 1'b1) $display("FAIL add_carry got %b want 1", carry_flag); else n_pass++;
    n_checks++; if (pc !== 8'h03) $display("FAIL add_pc got %h want 03", pc); else n_pass++;
    n_checks++; if (alu_func !== 4'b1111) $display("FAIL add_func_idle got %b want 1111", alu_func); else n_pass++;
    load_reg(3'd6, 8'h00);
    n_checks++; if (carry_flag !== 1'b1) $display("FAIL carry_hold got %b want 1", carry_flag); else n_pass++;
  endtask

  task automatic test_branch();
    load_reg(3'd3, 8'h05);
    load_reg(3'd0, 8'h05);
    load_reg(3'd7, 8'h40);
    run_instr({4'b1100, 3'd3, 2'd0});
    n_checks++; if (pc !== 8'h40) $display("FAIL be_taken_pc got %h want 40", pc); else n_pass++;
    n_checks++; if ({num_bran_taken, num_bran_not_taken} !== 8'h10) $display("FAIL be_taken_cnt got %h want 10", {num_bran_taken, num_bran_not_taken}); else n_pass++;
    load_reg(3'd0, 8'h06);
    run_instr({4'b1100, 3'd3, 2'd0});
    n_checks++; if (pc !== 8'h42) $display("FAIL be_not_pc got %h want 42", pc); else n_pass++;
    n_checks++; if ({num_bran_taken, num_bran_not_taken} !== 8'h11) $display("FAIL be_not_cnt got %h want 11", {num_bran_taken, num_bran_not_taken}); else n_pass++;
    run_instr({4'b1101, 3'd3, 2'd0});
    n_checks++; if (pc !== 8'h40) $display("FAIL blt_pc got %h want 40", pc); else n_pass++;
    n_checks++; if (num_bran_taken !== 4'd2) $display("FAIL blt_cnt got %h want 2", num_bran_taken); else n_pass++;
  endtask

  task automatic test_spec();
    load_reg(3'd2, 8'h78);
    res_ovr = 8'h02;
    issue(9'b0111_100_10);
    n_checks++; if ({alu_func, alu_spec} !== 7'b0111_100) $display("FAIL spec_issue got %b want 0111100", {alu_func, alu_spec}); else n_pass++;
    n_checks++; if ({alu_a, alu_b} !== 16'h7800) $display("FAIL spec_operands got %h want 7800", {alu_a, alu_b}); else n_pass++;
    finish_instr();
    peek(3'd2);
    n_checks++; if (rv !== 8'h02) $display("FAIL spec_r2 got %h want 02", rv); else n_pass++;
    n_checks++; if (illegal_op !== 1'b0) $display("FAIL spec_legal got %b want 0", illegal_op); else n_pass++;
    res_ovr = 8'h55;
    run_instr(9'b0111_010_10);
    peek(3'd2);
    n_checks++; if (rv !== 8'h02) $display("FAIL spec_bad_r2 got %h want 02", rv); else n_pass++;
    n_checks++; if (illegal_op !== 1'b1) $display("FAIL spec_bad_flag got %b want 1", illegal_op); else n_pass++;
    n_checks++; if (pc !== 8'h43) $display("FAIL spec_bad_pc got %h want 43", pc); else n_pass++;
  endtask

  task automatic test_move();
    run_instr({4'b0101, 3'd5, 2'd2});
    peek(3'd5);
    n_checks++; if (rv !== 8'h02) $display("FAIL stt_r5 got %h want 02", rv); else n_pass++;
    run_instr({4'b0110, 3'd1, 2'd3});
    peek(3'd3);
    n_checks++; if (rv !== 8'h10) $display("FAIL stf_r3 got %h want 10", rv); else n_pass++;
    res_ovr = 8'hAA;
    issue({4'b1010, 4'b0110, 1'b1});
    n_checks++; if ({alu_a, alu_b} !== 16'h1006) $display("FAIL slw_operands got %h want 1006", {alu_a, alu_b}); else n_pass++;
    finish_instr();
    peek(3'd1);
    n_checks++; if (rv !== 8'hAA) $display("FAIL slw_r1 got %h want aa", rv); else n_pass++;
    res_ovr = 8'h33;
    issue({4'b0001, 3'd1, 2'd0});
    n_checks++; if (alu_func !== 4'b0001) $display("FAIL illop_func got %b want 0001", alu_func); else n_pass++;
    finish_instr();
    peek(3'd1);
    n_checks++; if (rv !== 8'hAA) $display("FAIL illop_r1 got %h want aa", rv); else n_pass++;
    n_checks++; if (pc !== 8'h47) $display("FAIL illop_pc got %h want 47", pc); else n_pass++;
  endtask

  task automatic test_pc_wrap();
    load_reg(3'd7, 8'hFF);
    load_reg(3'd0, 8'h00);
    run_instr({4'b1100, 3'd0, 2'd0});
    n_checks++; if (pc !== 8'hFF) $display("FAIL wrap_pre got %h want ff", pc); else n_pass++;
    run_instr({4'b0000, 3'd0, 2'd0});
    n_checks++; if (pc !== 8'h00) $display("FAIL wrap_pc got %h want 00", pc); else n_pass++;
    n_checks++; if (carry_flag !== 1'b0) $display("FAIL wrap_carry got %b want 0", carry_flag); else n_pass++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 12; i++) run_instr({4'b1100, 3'd0, 2'd0});
    n_checks++; if (num_bran_taken !== 4'hF) $display("FAIL sat_reach got %h want f", num_bran_taken); else n_pass++;
    run_instr({4'b1100, 3'd0, 2'd0});
    n_checks++; if (num_bran_taken !== 4'hF) $display("FAIL sat_hold got %h want f", num_bran_taken); else n_pass++;
    n_checks++; if (pc !== 8'hFF) $display("FAIL sat_pc got %h want ff", pc); else n_pass++;
    n_checks++; if (num_bran_not_taken !== 4'h1) $display("FAIL sat_not got %h want 1", num_bran_not_taken); else n_pass++;
  endtask

  task automatic test_back_to_back();
    res_ovr = 8'h00;
    instr = {4'b0011, 3'd6, 2'd0};
    instr_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock); #1;
      n_checks++; if (instr_ready !== (k % 3 == 0)) $display("FAIL b2b_ready%0d got %b want %b", k, instr_ready, (k % 3 == 0)); else n_pass++;
    end
    instr_valid = 1'b0;
    n_checks++; if (pc !== 8'h02) $display("FAIL b2b_pc got %h want 02", pc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    load_reg(3'd4, 8'h99);
    peek(3'd4);
    n_checks++; if (rv !== 8'h99) $display("FAIL mid_pre_r4 got %h want 99", rv); else n_pass++;
    res_ovr = 8'h77;
    issue({4'b0011, 3'd4, 2'd0});
    reset_n = 1'b0;
    peek(3'd4);
    n_checks++; if (rv !== 8'h00) $display("FAIL mid_r4 got %h want 00", rv); else n_pass++;
    n_checks++; if (pc !== 8'h00) $display("FAIL mid_pc got %h want 00", pc); else n_pass++;
    n_checks++; if (alu_func !== 4'b1111) $display("FAIL mid_func got %b want 1111", alu_func); else n_pass++;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    peek(3'd4);
    n_checks++; if (instr_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", instr_ready); else n_pass++;
    n_checks++; if ({pc, rv} !== 16'h0000) $display("FAIL mid_after got %h want 0000", {pc, rv}); else n_pass++;
    load_reg(3'd4, 8'h12);
    peek(3'd4);
    n_checks++; if ({pc, rv} !== 16'h0112) $display("FAIL mid_resume got %h want 0112", {pc, rv}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_spec();
    test_move();
    test_pc_wrap();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
